alu_rs_scheduler: RTL

ALU_RS_SCHEDULER -- requirements
Module: alu_rs_scheduler

---
 rtl/alu_rs_scheduler.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_rs_scheduler.sv
// alu_rs_scheduler
//   Reservation station in front of a single ALU. Instructions are dispatched
//   into the lowest free slot. Pending operands snoop two result buses (ALU and
//   LSU) to pick up their values. Each cycle, the lowest-index entry whose
//   operands are both present is issued to a registered ALU port.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   rdy                      global stall (low = hold everything)
//   clr                      mispredict flush (works even while stalled)
//   disp_*                   dispatch request: opcode, dest tag, pc, imm, operands
//   cdb_a_* / cdb_b_*        result broadcasts (ALU / LSU); cdb_a wins on equal tags
//   alu_*                    registered issue to the ALU
//   full, count              occupancy
module alu_rs_scheduler #(
  parameter int ENTRIES = 8,
  parameter int TAG_W   = 4,
  parameter int OP_W    = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy,
  input  logic                       clr,
  input  logic                       disp_en,
  input  logic [OP_W-1:0]            disp_op,
  input  logic [TAG_W-1:0]           disp_rob,
  input  logic [31:0]                disp_pc,
  input  logic [31:0]                disp_imm,
  input  logic                       disp_qj_busy,
  input  logic                       disp_qk_busy,
  input  logic [TAG_W-1:0]           disp_qj,
  input  logic [TAG_W-1:0]           disp_qk,
  input  logic [31:0]                disp_vj,
  input  logic [31:0]                disp_vk,
  input  logic                       cdb_a_en,
  input  logic [TAG_W-1:0]           cdb_a_rob,
  input  logic [31:0]                cdb_a_val,
  input  logic                       cdb_b_en,
  input  logic [TAG_W-1:0]           cdb_b_rob,
  input  logic [31:0]                cdb_b_val,
  output logic                       alu_en,
  output logic [OP_W-1:0]            alu_op,
  output logic [31:0]                alu_vj,
  output logic [31:0]                alu_vk,
  output logic [31:0]                alu_imm,
  output logic [31:0]                alu_pc,
  output logic [TAG_W-1:0]           alu_rob,
  output logic                       full,
  output logic [$clog2(ENTRIES):0]   count
);

  localparam int IW = $clog2(ENTRIES);
  localparam int CW = IW + 1;

  logic [ENTRIES-1:0]            busy_q, busy_d;
  logic [ENTRIES-1:0][OP_W-1:0]  op_q, op_d;
  logic [ENTRIES-1:0][TAG_W-1:0] rob_q, rob_d;
  logic [ENTRIES-1:0][31:0]      pc_q, pc_d;
  logic [ENTRIES-1:0][31:0]      imm_q, imm_d;
  logic [ENTRIES-1:0][31:0]      vj_q, vj_d;
  logic [ENTRIES-1:0][31:0]      vk_q, vk_d;
  logic [ENTRIES-1:0][TAG_W-1:0] qj_q, qj_d;
  logic [ENTRIES-1:0][TAG_W-1:0] qk_q, qk_d;
  logic [ENTRIES-1:0]            qjb_q, qjb_d;
  logic [ENTRIES-1:0]            qkb_q, qkb_d;
  logic [CW-1:0]                 count_q, count_d;

  logic                          alu_en_q, alu_en_d;
  logic [OP_W-1:0]               alu_op_q, alu_op_d;
  logic [31:0]                   alu_vj_q, alu_vj_d;
  logic [31:0]                   alu_vk_q, alu_vk_d;
  logic [31:0]                   alu_imm_q, alu_imm_d;
  logic [31:0]                   alu_pc_q, alu_pc_d;
  logic [TAG_W-1:0]              alu_rob_q, alu_rob_d;

  logic [ENTRIES-1:0]            ready;
  logic                          issue_vld, free_vld, disp_ok;
  logic [IW-1:0]                 issue_idx, free_idx;
  logic [32:0]                   snp_j, snp_k;

  // Returns {still_pending, value}. cdb_a is checked first so it wins a tag tie.
  function automatic logic [32:0] snoop(input logic pend, input logic [TAG_W-1:0] tag,
                                        input logic [31:0] val);
    logic [32:0] r;
    r = {pend, val};
    if (pend && cdb_a_en && (tag == cdb_a_rob))
      r = {1'b0, cdb_a_val};
    else if (pend && cdb_b_en && (tag == cdb_b_rob))
      r = {1'b0, cdb_b_val};
    return r;
  endfunction

  assign full = (count_q == CW'(ENTRIES));

  // Selection uses registered state only, so a slot woken or freed this cycle
  // cannot be issued or re-used until the next one.
  always_comb begin
    ready     = busy_q & ~qjb_q & ~qkb_q;
    issue_vld = 1'b0;
    issue_idx = '0;
    free_vld  = 1'b0;
    free_idx  = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (ready[i]) begin
        issue_vld = 1'b1;
        issue_idx = IW'(i);
      end
      if (!busy_q[i]) begin
        free_vld = 1'b1;
        free_idx = IW'(i);
      end
    end
    disp_ok = disp_en && !full && free_vld;
  end

  always_comb begin
    busy_d    = busy_q;
    op_d      = op_q;
    rob_d     = rob_q;
    pc_d      = pc_q;
    imm_d     = imm_q;
    vj_d      = vj_q;
    vk_d      = vk_q;
    qj_d      = qj_q;
    qk_d      = qk_q;
    qjb_d     = qjb_q;
    qkb_d     = qkb_q;
    count_d   = count_q;
    alu_en_d  = alu_en_q;
    alu_op_d  = alu_op_q;
    alu_vj_d  = alu_vj_q;
    alu_vk_d  = alu_vk_q;
    alu_imm_d = alu_imm_q;
    alu_pc_d  = alu_pc_q;
    alu_rob_d = alu_rob_q;
    snp_j     = '0;
    snp_k     = '0;

    if (rdy) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (busy_q[i]) begin
          snp_j    = snoop(qjb_q[i], qj_q[i], vj_q[i]);
          snp_k    = snoop(qkb_q[i], qk_q[i], vk_q[i]);
          qjb_d[i] = snp_j[32];
          vj_d[i]  = snp_j[31:0];
          qkb_d[i] = snp_k[32];
          vk_d[i]  = snp_k[31:0];
        end
      end

      alu_en_d = issue_vld;
      if (issue_vld) begin
        busy_d[issue_idx] = 1'b0;
        alu_op_d          = op_q[issue_idx];
        alu_vj_d          = vj_q[issue_idx];
        alu_vk_d          = vk_q[issue_idx];
        alu_imm_d         = imm_q[issue_idx];
        alu_pc_d          = pc_q[issue_idx];
        alu_rob_d         = rob_q[issue_idx];
      end

      // Dispatch bypass: operands produced on a CDB this very cycle land ready.
      if (disp_ok) begin
        snp_j            = snoop(disp_qj_busy, disp_qj, disp_vj);
        snp_k            = snoop(disp_qk_busy, disp_qk, disp_vk);
        busy_d[free_idx] = 1'b1;
        op_d[free_idx]   = disp_op;
        rob_d[free_idx]  = disp_rob;
        pc_d[free_idx]   = disp_pc;
        imm_d[free_idx]  = disp_imm;
        qj_d[free_idx]   = disp_qj;
        qk_d[free_idx]   = disp_qk;
        qjb_d[free_idx]  = snp_j[32];
        vj_d[free_idx]   = snp_j[31:0];
        qkb_d[free_idx]  = snp_k[32];
        vk_d[free_idx]   = snp_k[31:0];
      end

      count_d = count_q + CW'(disp_ok) - CW'(issue_vld);
    end

    if (clr) begin
      busy_d   = '0;
      alu_en_d = 1'b0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q    <= '0;
      op_q      <= '0;
      rob_q     <= '0;
      pc_q      <= '0;
      imm_q     <= '0;
      vj_q      <= '0;
      vk_q      <= '0;
      qj_q      <= '0;
      qk_q      <= '0;
      qjb_q     <= '0;
      qkb_q     <= '0;
      count_q   <= '0;
      alu_en_q  <= 1'b0;
      alu_op_q  <= '0;
      alu_vj_q  <= '0;
      alu_vk_q  <= '0;
      alu_imm_q <= '0;
      alu_pc_q  <= '0;
      alu_rob_q <= '0;
    end else begin
      busy_q    <= busy_d;
      op_q      <= op_d;
      rob_q     <= rob_d;
      pc_q      <= pc_d;
      imm_q     <= imm_d;
      vj_q      <= vj_d;
      vk_q      <= vk_d;
      qj_q      <= qj_d;
      qk_q      <= qk_d;
      qjb_q     <= qjb_d;
      qkb_q     <= qkb_d;
      count_q   <= count_d;
      alu_en_q  <= alu_en_d;
      alu_op_q  <= alu_op_d;
      alu_vj_q  <= alu_vj_d;
      alu_vk_q  <= alu_vk_d;
      alu_imm_q <= alu_imm_d;
      alu_pc_q  <= alu_pc_d;
      alu_rob_q <= alu_rob_d;
    end
  end

  assign alu_en  = alu_en_q;
  assign alu_op  = alu_op_q;
  assign alu_vj  = alu_vj_q;
  assign alu_vk  = alu_vk_q;
  assign alu_imm = alu_imm_q;
  assign alu_pc  = alu_pc_q;
  assign alu_rob = alu_rob_q;
  assign count   = count_q;

endmodule
